// File: rtl/dmem_line_responder_pkg.sv
// Shared types, line geometry constants and the beat address helper
// for the data-cache line responder.
package dmem_pkg;

  localparam int LINE_BITS         = 512;
  localparam int BEAT_BITS         = 64;
  localparam int LINE_BYTES        = 64;
  localparam int BEATS_PER_LINE    = 8;
  localparam int LINE_OFFSET_WIDTH = 6;
  localparam int BEAT_IDX_WIDTH    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Byte address of beat idx within the line identified by its tag (addr[63:6]).
  function automatic logic [63:0] beat_addr(input logic [63-LINE_OFFSET_WIDTH:0] tag,
                                            input logic [BEAT_IDX_WIDTH-1:0] idx);
    return {tag, idx, 3'b000};
  endfunction

endpackage

// File: rtl/dmem_line_responder_if.sv
// Bundle of the cache-side line handshake and the downstream beat bus.
// slave is the responder's view; master is the cache plus memory adapter.
interface dmem_line_responder_if;

  logic         drequest;
  logic         dreqack;
  logic         dwrenable;
  logic [63:0]  daddr;
  logic [511:0] dwdata;
  logic [511:0] drdata;
  logic         ddone;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_write;
  logic [63:0]  mem_req_addr;
  logic [63:0]  mem_req_wdata;
  logic         mem_resp_valid;
  logic [63:0]  mem_resp_rdata;

  modport slave (
    input  drequest, dwrenable, daddr, dwdata,
    output dreqack, drdata, ddone,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport master (
    output drequest, dwrenable, daddr, dwdata,
    input  dreqack, drdata, ddone,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

endinterface

// File: rtl/dmem_line_responder_chk.sv
// Protocol checks for the line responder: stray read responses and
// request fields moving while a request waits for its acknowledge.
module dmem_line_responder_chk
  import dmem_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  input state_e       state,
  input logic [3:0]   issued,
  input logic [3:0]   recv,
  input logic         drequest,
  input logic         dreqack,
  input logic         dwrenable,
  input logic [63:0]  daddr,
  input logic [511:0] dwdata,
  input logic         mem_resp_valid
);

  resp_in_window: assert property (@(posedge clk) disable iff (!rst_n)
    mem_resp_valid |-> (state == RD && recv < issued))
    else $fatal(1, "dmem_line_responder: read response with no outstanding read beat");

  req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (drequest && !dreqack && $past(drequest) && !$past(dreqack))
      |-> ($stable(dwrenable) && $stable(daddr) && $stable(dwdata)))
    else $fatal(1, "dmem_line_responder: request fields changed before acknowledge");

endmodule

// File: rtl/dmem_line_responder_line_beat_buffer.sv
// 8 x 64-bit line buffer: whole-line load or single-beat write,
// one beat-indexed read port and the full line as a flat vector.
module line_beat_buffer
  import dmem_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [LINE_BITS-1:0]      load_line,
  input  logic                      wr_en,
  input  logic [BEAT_IDX_WIDTH-1:0] wr_idx,
  input  logic [BEAT_BITS-1:0]      wr_beat,
  input  logic [BEAT_IDX_WIDTH-1:0] rd_idx,
  output logic [BEAT_BITS-1:0]      rd_beat,
  output logic [LINE_BITS-1:0]      line_out
);

  logic [BEAT_BITS-1:0] mem [BEATS_PER_LINE];

  // Storage: clear on reset, whole-line load wins over a beat write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BEATS_PER_LINE; i++) mem[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < BEATS_PER_LINE; i++) mem[i] <= load_line[i*BEAT_BITS +: BEAT_BITS];
    end else if (wr_en) begin
      mem[wr_idx] <= wr_beat;
    end
  end

  assign rd_beat = mem[rd_idx];

  // Flatten the beats into a line, beat 0 in the low bits.
  always_comb begin
    line_out = '0;
    for (int i = 0; i < BEATS_PER_LINE; i++) line_out[i*BEAT_BITS +: BEAT_BITS] = mem[i];
  end

endmodule

// File: rtl/dmem_line_responder.sv
// Memory-side responder for the DCache line interface: captures one
// 64-byte transaction, issues eight 64-bit beats downstream and, for
// reads, reassembles the returned beats into the line.
module dmem_line_responder
  import dmem_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  dmem_line_responder_if.slave bus
);

  state_e         state, state_next;
  logic [57:0]    line_tag;
  logic           is_wr;
  logic           ack;
  logic [3:0]     issued;
  logic [3:0]     recv;
  logic           capture;
  logic           req_valid;
  logic           req_fire;
  logic           resp_fire;
  logic [63:0]    rd_beat;
  logic [511:0]   line_out;
  logic [511:0]   load_line;

  assign capture   = (state == IDLE) && bus.drequest;
  assign req_valid = ((state == RD) || (state == WR)) && (issued < 4'd8);
  assign req_fire  = req_valid && bus.mem_req_ready;
  assign resp_fire = (state == RD) && bus.mem_resp_valid && (recv < 4'd8);
  // Reads start from a zeroed buffer so nothing from an earlier line survives.
  assign load_line = bus.dwrenable ? bus.dwdata : 512'd0;

  // Next-state decode: leave RD on the eighth response, WR on the eighth accepted beat.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.drequest) state_next = bus.dwrenable ? WR : RD;
        else              state_next = IDLE;
      end
      RD: begin
        if (resp_fire && (recv == 4'd7)) state_next = DONE;
        else                             state_next = RD;
      end
      WR: begin
        if (req_fire && (issued == 4'd7)) state_next = DONE;
        else                              state_next = WR;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, latched request and beat counters; counters saturate at 8 by construction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      line_tag <= 58'd0;
      is_wr    <= 1'b0;
      ack      <= 1'b0;
      issued   <= 4'd0;
      recv     <= 4'd0;
    end else begin
      state <= state_next;
      ack   <= capture;
      if (capture) begin
        line_tag <= bus.daddr[63:6];
        is_wr    <= bus.dwrenable;
        issued   <= 4'd0;
        recv     <= 4'd0;
      end else begin
        if (req_fire)  issued <= issued + 4'd1;
        if (resp_fire) recv   <= recv + 4'd1;
      end
    end
  end

  line_beat_buffer u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (capture),
    .load_line (load_line),
    .wr_en     (resp_fire),
    .wr_idx    (recv[2:0]),
    .wr_beat   (bus.mem_resp_rdata),
    .rd_idx    (issued[2:0]),
    .rd_beat   (rd_beat),
    .line_out  (line_out)
  );

  // Outputs decode only from registers; beat fields are held by the counters during stalls.
  assign bus.dreqack       = ack;
  assign bus.ddone         = (state == DONE);
  assign bus.drdata        = ((state == DONE) && !is_wr) ? line_out : 512'd0;
  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_write = req_valid && (state == WR);
  assign bus.mem_req_addr  = req_valid ? beat_addr(line_tag, issued[2:0]) : 64'd0;
  assign bus.mem_req_wdata = (req_valid && (state == WR)) ? rd_beat : 64'd0;

  dmem_line_responder_chk u_chk (
    .clk            (clk),
    .rst_n          (rst_n),
    .state          (state),
    .issued         (issued),
    .recv           (recv),
    .drequest       (bus.drequest),
    .dreqack        (bus.dreqack),
    .dwrenable      (bus.dwrenable),
    .daddr          (bus.daddr),
    .dwdata         (bus.dwdata),
    .mem_resp_valid (bus.mem_resp_valid)
  );

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: a table of line transactions
// plus hand-written back-to-back and mid-transaction reset sequences.
module tb_dmem_line_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_line_responder_if bus();

  dmem_line_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] base;
    int          rmode;
    int          maxd;
    logic [63:0] exp_line;
    int          exp_done;
  } vec_t;

  vec_t vecs[7];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_beats = 0;
  int stab_bad = 0;
  int last_due = 0;
  int ready_mode = 0;
  int max_delay = 0;
  int last_ack_abs = 0;
  int last_done_abs = 0;
  logic [63:0] txn_base = 64'd0;
  logic [63:0] log_addr[16];
  logic [63:0] log_wdata[16];
  logic        log_write[16];
  logic [63:0] q_data[$];
  int          q_due[$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock: observe what the DUT saw at the edge, then update the memory model and inputs.
  task automatic step();
    logic        fire, resp_taken, rst_at_edge, stall;
    logic [63:0] a, w, pa, pw;
    logic        wf, pwf;
    int          d, due;
    fire        = bus.mem_req_valid && bus.mem_req_ready;
    stall       = bus.mem_req_valid && !bus.mem_req_ready;
    a           = bus.mem_req_addr;
    w           = bus.mem_req_wdata;
    wf          = bus.mem_req_write;
    pa = a; pw = w; pwf = wf;
    resp_taken  = bus.mem_resp_valid;
    rst_at_edge = !rst_n;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_at_edge) begin
      q_data.delete();
      q_due.delete();
      last_due = 0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = 64'd0;
    end else begin
      if (resp_taken && q_due.size() > 0) begin
        void'(q_due.pop_front());
        void'(q_data.pop_front());
      end
      if (fire && n_beats < 16) begin
        log_addr[n_beats]  = a;
        log_wdata[n_beats] = w;
        log_write[n_beats] = wf;
        n_beats++;
        if (!wf) begin
          d = (max_delay == 0) ? 0 : int'($urandom_range(0, max_delay));
          due = cyc + d;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          q_due.push_back(due);
          q_data.push_back(txn_base + {61'd0, a[5:3]});
        end
      end
      if (stall && (bus.mem_req_addr !== pa || bus.mem_req_wdata !== pw ||
                    bus.mem_req_write !== pwf || bus.mem_req_valid !== 1'b1))
        stab_bad++;
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = q_data[0];
      end else begin
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = 64'd0;
      end
      case (ready_mode)
        0:       bus.mem_req_ready = 1'b1;
        1:       bus.mem_req_ready = ~bus.mem_req_ready;
        default: bus.mem_req_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  endtask

  task automatic run_txn(input string tag, input logic wr, input logic [63:0] addr,
                         input logic [63:0] base, input int rmode, input int maxd,
                         input logic [63:0] exp_line, input int exp_done);
    logic [511:0] line, got, exp_rd;
    int start, r, ack_cnt, done_cnt, ack_rel, done_rel, idle_bad;
    bit finished;
    n_beats = 0; stab_bad = 0; idle_bad = 0;
    txn_base = base; ready_mode = rmode; max_delay = maxd;
    for (int k = 0; k < 8; k++) line[k*64 +: 64] = base + 64'(k);
    bus.mem_req_ready = 1'b1;
    bus.dwrenable = wr;
    bus.daddr     = addr;
    bus.dwdata    = wr ? line : 512'd0;
    bus.drequest  = 1'b1;
    start = cyc; ack_cnt = 0; done_cnt = 0; ack_rel = -1; done_rel = -1;
    got = 512'd0; finished = 1'b0;
    for (int i = 0; i < 300 && !finished; i++) begin
      step();
      r = cyc - start;
      if (bus.dreqack) begin
        ack_cnt++;
        if (ack_rel < 0) begin ack_rel = r; last_ack_abs = cyc; end
        bus.drequest = 1'b0;
      end
      if (bus.ddone) begin
        done_cnt++;
        if (done_rel < 0) begin done_rel = r; last_done_abs = cyc; got = bus.drdata; end
      end else if (bus.drdata !== 512'd0) begin
        idle_bad++;
      end
      if (done_rel >= 0 && r > done_rel) finished = 1'b1;
    end
    bus.drequest = 1'b0;
    check({tag, " finished"}, 512'(finished), 512'd1);
    check({tag, " ack_rel"}, 512'(ack_rel), 512'd1);
    check({tag, " ack_cnt"}, 512'(ack_cnt), 512'd1);
    check({tag, " done_cnt"}, 512'(done_cnt), 512'd1);
    if (exp_done > 0) check({tag, " done_rel"}, 512'(done_rel), 512'(exp_done));
    check({tag, " n_beats"}, 512'(n_beats), 512'd8);
    for (int k = 0; k < 8 && k < n_beats; k++)
      check($sformatf("%s beat%0d", tag, k),
            {log_write[k], log_addr[k], log_wdata[k]},
            {wr, exp_line + 64'(8 * k), wr ? base + 64'(k) : 64'd0});
    for (int k = 0; k < 8; k++) exp_rd[k*64 +: 64] = base + 64'(k);
    check({tag, " drdata"}, got, wr ? 512'd0 : exp_rd);
    check({tag, " drdata_idle"}, 512'(idle_bad), 512'd0);
    if (rmode != 0) check({tag, " hold"}, 512'(stab_bad), 512'd0);
  endtask

  initial begin
    int first_done;
    vecs[0] = '{1'b0, 64'h1000, 64'hA0, 0, 0, 64'h1000, 10};
    vecs[1] = '{1'b1, 64'h2040, 64'hB0, 1, 0, 64'h2040, -1};
    vecs[2] = '{1'b0, 64'h3027, 64'hC0, 0, 0, 64'h3000, 10};
    vecs[3] = '{1'b0, 64'h5a80, 64'h1111_0000, 2, 5, 64'h5a80, -1};
    vecs[4] = '{1'b1, 64'hffff_ffff_ffff_ffc0, 64'hdead_0000, 2, 0, 64'hffff_ffff_ffff_ffc0, -1};
    vecs[5] = '{1'b0, 64'h7fc0, 64'h5500, 2, 5, 64'h7fc0, -1};
    vecs[6] = '{1'b1, 64'h8008, 64'h70, 0, 0, 64'h8000, 9};

    bus.drequest = 1'b0; bus.dwrenable = 1'b0; bus.daddr = 64'd0; bus.dwdata = 512'd0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = 64'd0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("reset ctl", {bus.dreqack, bus.ddone, bus.mem_req_valid, bus.mem_req_write}, 512'd0);
    check("reset addr", bus.mem_req_addr, 512'd0);
    check("reset wdata", bus.mem_req_wdata, 512'd0);
    check("reset drdata", bus.drdata, 512'd0);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 7; v++)
      run_txn($sformatf("vec%0d", v), vecs[v].wr, vecs[v].addr, vecs[v].base,
              vecs[v].rmode, vecs[v].maxd, vecs[v].exp_line, vecs[v].exp_done);

    // Write completion immediately followed by a read request.
    run_txn("b2b_wr", 1'b1, 64'h2040, 64'hB0, 0, 0, 64'h2040, 9);
    first_done = last_done_abs;
    run_txn("b2b_rd", 1'b0, 64'h1000, 64'hA0, 0, 0, 64'h1000, 10);
    check("b2b gap", 512'(last_ack_abs - first_done), 512'd2);

    // Reset after three read beats accepted, then a clean read.
    n_beats = 0; txn_base = 64'hE0; ready_mode = 0; max_delay = 0;
    bus.mem_req_ready = 1'b1;
    bus.dwrenable = 1'b0; bus.daddr = 64'h4000; bus.dwdata = 512'd0; bus.drequest = 1'b1;
    for (int i = 0; i < 50 && n_beats < 3; i++) begin
      step();
      if (bus.dreqack) bus.drequest = 1'b0;
    end
    check("rst n_beats", 512'(n_beats), 512'd3);
    bus.drequest = 1'b0;
    rst_n = 1'b0;
    step();
    check("rst ctl", {bus.dreqack, bus.ddone, bus.mem_req_valid, bus.mem_req_write}, 512'd0);
    check("rst addr", bus.mem_req_addr, 512'd0);
    check("rst wdata", bus.mem_req_wdata, 512'd0);
    check("rst drdata", bus.drdata, 512'd0);
    check("rst state", 512'(dut.state), 512'(IDLE));
    rst_n = 1'b1;
    step();
    run_txn("post_rst", 1'b0, 64'h4000, 64'h60, 0, 0, 64'h4000, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
